// File: rtl/cell_sort_ctrl_pkg.sv
// Shared types and defaults for the systolic insertion-sort sequencer.
// Optional build macro CELL_SORT_CTRL_TIMEOUT_EN is consumed by cell_sort_ctrl.
package cell_sort_pkg;

   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      LOAD   = 2'd1,
      SETTLE = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   localparam int NCELLS_DEF = 16;
   localparam int SORTB_DEF  = 8;
   localparam int METAB_DEF  = 32;
   localparam int CNTB_DEF   = $clog2(NCELLS_DEF + 1);

   // Key of cell idx from a default-sized flattened cell bus.
   function automatic logic [SORTB_DEF-1:0] cell_sel(
      input logic [NCELLS_DEF*SORTB_DEF-1:0] flat,
      input logic [CNTB_DEF-1:0]             idx
   );
      logic [SORTB_DEF-1:0] sel;
      sel = '0;
      for (int k = 0; k < NCELLS_DEF; k++) begin
         if (idx == CNTB_DEF'(k)) sel = flat[k*SORTB_DEF +: SORTB_DEF];
      end
      return sel;
   endfunction

endpackage

// File: rtl/cell_sort_ctrl_if.sv
// Item ingest and sorted output streams of the sort sequencer.
// Signal suffixes are from the controller's point of view.
interface cell_sort_if #(
   parameter int SORTB = 8,
   parameter int METAB = 32
);
   logic [SORTB-1:0] in_data_i;
   logic [METAB-1:0] in_meta_i;
   logic             in_last_i;
   logic             in_valid_i;
   logic             in_ready_o;

   logic [SORTB-1:0] out_data_o;
   logic [METAB-1:0] out_meta_o;
   logic             out_last_o;
   logic             out_valid_o;
   logic             out_ready_i;

   modport slave (
      input  in_data_i, in_meta_i, in_last_i, in_valid_i, out_ready_i,
      output in_ready_o, out_data_o, out_meta_o, out_last_o, out_valid_o
   );

   modport master (
      output in_data_i, in_meta_i, in_last_i, in_valid_i, out_ready_i,
      input  in_ready_o, out_data_o, out_meta_o, out_last_o, out_valid_o
   );
endinterface

// File: rtl/cell_sort_ctrl_rdmux.sv
// NCELLS:1 read mux selecting one cell's key and metadata by index.
// Indices at or beyond NCELLS select zero.
module cell_sort_rdmux
   import cell_sort_pkg::*;
#(
   parameter int NCELLS = NCELLS_DEF,
   parameter int SORTB  = SORTB_DEF,
   parameter int METAB  = METAB_DEF,
   parameter int CNTB   = $clog2(NCELLS + 1)
) (
   input  logic [NCELLS*SORTB-1:0] data_flat_i,
   input  logic [NCELLS*METAB-1:0] meta_flat_i,
   input  logic [CNTB-1:0]         idx_i,
   output logic [SORTB-1:0]        data_o,
   output logic [METAB-1:0]        meta_o
);

   always_comb begin
      data_o = '0;
      meta_o = '0;
      for (int k = 0; k < NCELLS; k++) begin
         if (idx_i == CNTB'(k)) begin
            data_o = data_flat_i[k*SORTB +: SORTB];
            meta_o = meta_flat_i[k*METAB +: METAB];
         end
      end
   end

endmodule

// File: rtl/cell_sort_ctrl.sv
// Frame sequencer for a systolic insertion-sort cell array: load, settle, drain, clear.
// Build macro CELL_SORT_CTRL_TIMEOUT_EN adds an idle auto-flush after TIMEOUT cycles.
//
// state  | meaning
// CLEAR  | one-cycle array clear; counters and overflow zeroed
// LOAD   | accept items, broadcast each to the array with a dav strobe
// SETTLE | one cycle for the final dav to land in the cells
// DRAIN  | stream cells out by index, cell 0 first
module cell_sort_ctrl
   import cell_sort_pkg::*;
#(
   parameter int NCELLS = NCELLS_DEF,
   parameter int SORTB  = SORTB_DEF,
   parameter int METAB  = METAB_DEF
`ifdef CELL_SORT_CTRL_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 64
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   cell_sort_if.slave              sif,
   output logic [SORTB-1:0]        arr_data_o,
   output logic [METAB-1:0]        arr_meta_o,
   output logic                    arr_dav_o,
   output logic                    arr_clr_o,
   input  logic [NCELLS*SORTB-1:0] arr_data_i,
   input  logic [NCELLS*METAB-1:0] arr_meta_i,
   output logic                    overflow_o,
   output logic                    busy_o
);

   localparam int CNTB = $clog2(NCELLS + 1);

   state_t            state_q, state_d;
   logic [CNTB-1:0]   count_q, count_d;
   logic [CNTB-1:0]   rd_idx_q, rd_idx_d;
   logic              overflow_q, overflow_d;
   logic [SORTB-1:0]  arr_data_q, arr_data_d;
   logic [METAB-1:0]  arr_meta_q, arr_meta_d;
   logic              arr_dav_q, arr_dav_d;

   logic              hs_in, hs_out, last_idx, idle_tc;
   logic [SORTB-1:0]  sel_data;
   logic [METAB-1:0]  sel_meta;

   assign hs_in    = (state_q == LOAD) && sif.in_valid_i;
   assign hs_out   = (state_q == DRAIN) && sif.out_ready_i;
   assign last_idx = (rd_idx_q == count_q - CNTB'(1));

`ifdef CELL_SORT_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] idle_q, idle_d;

   // Down-counter reloaded on every handshake and outside LOAD; zero is the idle limit.
   always_comb begin
      idle_d = idle_q;
      if (state_q != LOAD || hs_in) idle_d = TW'(TIMEOUT - 1);
      else if (idle_q != '0)        idle_d = idle_q - TW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) idle_q <= TW'(TIMEOUT - 1);
      else     idle_q <= idle_d;
   end

   assign idle_tc = (idle_q == '0) && (count_q != '0);
`else
   assign idle_tc = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rd_idx_d   = rd_idx_q;
      overflow_d = overflow_q;
      arr_data_d = arr_data_q;
      arr_meta_d = arr_meta_q;
      arr_dav_d  = 1'b0;
      case (state_q)
         CLEAR: begin
            count_d    = '0;
            rd_idx_d   = '0;
            overflow_d = 1'b0;
            state_d    = LOAD;
         end
         LOAD: begin
            if (hs_in) begin
               if (count_q < CNTB'(NCELLS)) begin
                  arr_data_d = sif.in_data_i;
                  arr_meta_d = sif.in_meta_i;
                  arr_dav_d  = 1'b1;
                  count_d    = count_q + CNTB'(1);
               end else begin
                  overflow_d = 1'b1;
               end
               if (sif.in_last_i) state_d = SETTLE;
            end else if (idle_tc) begin
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            state_d = (count_q == '0) ? CLEAR : DRAIN;
         end
         DRAIN: begin
            if (hs_out) begin
               rd_idx_d = rd_idx_q + CNTB'(1);
               if (last_idx) state_d = CLEAR;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR;
         count_q    <= '0;
         rd_idx_q   <= '0;
         overflow_q <= 1'b0;
         arr_data_q <= '0;
         arr_meta_q <= '0;
         arr_dav_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rd_idx_q   <= rd_idx_d;
         overflow_q <= overflow_d;
         arr_data_q <= arr_data_d;
         arr_meta_q <= arr_meta_d;
         arr_dav_q  <= arr_dav_d;
      end
   end

   cell_sort_rdmux #(
      .NCELLS (NCELLS),
      .SORTB  (SORTB),
      .METAB  (METAB),
      .CNTB   (CNTB)
   ) u_rdmux (
      .data_flat_i (arr_data_i),
      .meta_flat_i (arr_meta_i),
      .idx_i       (rd_idx_q),
      .data_o      (sel_data),
      .meta_o      (sel_meta)
   );

   assign sif.in_ready_o  = (state_q == LOAD);
   assign sif.out_valid_o = (state_q == DRAIN);
   assign sif.out_last_o  = (state_q == DRAIN) && last_idx;
   assign sif.out_data_o  = (state_q == DRAIN) ? sel_data : '0;
   assign sif.out_meta_o  = (state_q == DRAIN) ? sel_meta : '0;

   assign arr_data_o = arr_data_q;
   assign arr_meta_o = arr_meta_q;
   assign arr_dav_o  = arr_dav_q;
   assign arr_clr_o  = (state_q == CLEAR);
   assign overflow_o = overflow_q;
   assign busy_o     = (state_q != LOAD);

endmodule

// File: tb/tb_cell_sort_ctrl.sv
// Directed bench for cell_sort_ctrl with a behavioural descending insertion-sort array.
// Build with CELL_SORT_CTRL_TIMEOUT_EN defined to exercise the idle auto-flush.
module tb_cell_sort_ctrl;

   localparam int NC = 16;
   localparam int SB = 8;
   localparam int MB = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [SB-1:0]    arr_data_o;
   logic [MB-1:0]    arr_meta_o;
   logic             arr_dav_o, arr_clr_o, overflow_o, busy_o;
   logic [NC*SB-1:0] arr_data_i;
   logic [NC*MB-1:0] arr_meta_i;

   cell_sort_if #(.SORTB(SB), .METAB(MB)) sif ();

`ifdef CELL_SORT_CTRL_TIMEOUT_EN
   cell_sort_ctrl #(.NCELLS(NC), .SORTB(SB), .METAB(MB), .TIMEOUT(8)) dut (
`else
   cell_sort_ctrl #(.NCELLS(NC), .SORTB(SB), .METAB(MB)) dut (
`endif
      .clk        (clk),
      .rst        (rst),
      .sif        (sif),
      .arr_data_o (arr_data_o),
      .arr_meta_o (arr_meta_o),
      .arr_dav_o  (arr_dav_o),
      .arr_clr_o  (arr_clr_o),
      .arr_data_i (arr_data_i),
      .arr_meta_i (arr_meta_i),
      .overflow_o (overflow_o),
      .busy_o     (busy_o)
   );

   // Cell array model: cell 0 holds the largest key, equal keys keep arrival order.
   logic [SB-1:0] ck [NC];
   logic [MB-1:0] cm [NC];
   logic          cv [NC];
   int            ins_pos;

   always_comb begin
      ins_pos = NC;
      for (int k = NC - 1; k >= 0; k--) begin
         if (!cv[k] || arr_data_o > ck[k]) ins_pos = k;
      end
   end

   always @(posedge clk) begin
      if (arr_clr_o) begin
         for (int k = 0; k < NC; k++) begin
            cv[k] <= 1'b0;
            ck[k] <= '0;
            cm[k] <= '0;
         end
      end else if (arr_dav_o) begin
         for (int k = 1; k < NC; k++) begin
            if (k > ins_pos) begin
               ck[k] <= ck[k-1];
               cm[k] <= cm[k-1];
               cv[k] <= cv[k-1];
            end
         end
         for (int k = 0; k < NC; k++) begin
            if (k == ins_pos) begin
               ck[k] <= arr_data_o;
               cm[k] <= arr_meta_o;
               cv[k] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      arr_data_i = '0;
      arr_meta_i = '0;
      for (int k = 0; k < NC; k++) begin
         arr_data_i[k*SB +: SB] = cv[k] ? ck[k] : '0;
         arr_meta_i[k*MB +: MB] = cv[k] ? cm[k] : '0;
      end
   end

   int total = 0;
   int bad   = 0;
   logic [SB-1:0] exp_k [NC];

   function automatic logic [MB-1:0] meta_of(input logic [SB-1:0] k);
      return 32'hC0DE_0000 | {16'h0, ~k, k};
   endfunction

   task automatic send(input logic [SB-1:0] k, input logic last);
      sif.in_valid_i = 1'b1;
      sif.in_data_i  = k;
      sif.in_meta_i  = meta_of(k);
      sif.in_last_i  = last;
      @(negedge clk);
   endtask

   task automatic go_idle();
      sif.in_valid_i = 1'b0;
      sif.in_last_i  = 1'b0;
   endtask

   // Expects n items from exp_k in order, then one CLEAR cycle, then LOAD.
   task automatic drain_check(input int n, input string tag);
      int w;
      w = 0;
      sif.out_ready_i = 1'b1;
      while (sif.out_valid_o !== 1'b1 && w < 8) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (sif.out_valid_o !== 1'b1) begin
         bad++; $display("FAIL %s_valid_wait got=%b exp=1", tag, sif.out_valid_o);
      end
      for (int i = 0; i < n; i++) begin
         total++;
         if (sif.out_valid_o !== 1'b1 || sif.out_data_o !== exp_k[i]) begin
            bad++; $display("FAIL %s_data[%0d] got=%0d/v%b exp=%0d", tag, i, sif.out_data_o, sif.out_valid_o, exp_k[i]);
         end
         total++;
         if (sif.out_meta_o !== meta_of(exp_k[i])) begin
            bad++; $display("FAIL %s_meta[%0d] got=%h exp=%h", tag, i, sif.out_meta_o, meta_of(exp_k[i]));
         end
         total++;
         if (sif.out_last_o !== (i == n - 1)) begin
            bad++; $display("FAIL %s_last[%0d] got=%b exp=%b", tag, i, sif.out_last_o, (i == n - 1));
         end
         @(negedge clk);
      end
      total++;
      if (arr_clr_o !== 1'b1 || sif.out_valid_o !== 1'b0) begin
         bad++; $display("FAIL %s_clear got clr=%b valid=%b exp clr=1 valid=0", tag, arr_clr_o, sif.out_valid_o);
      end
      @(negedge clk);
      total++;
      if (arr_clr_o !== 1'b0 || sif.in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         bad++; $display("FAIL %s_reload got clr=%b rdy=%b busy=%b exp 0/1/0", tag, arr_clr_o, sif.in_ready_o, busy_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      total++;
      if (arr_clr_o !== 1'b1 || sif.in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
         bad++; $display("FAIL rst_clear got clr=%b rdy=%b busy=%b exp 1/0/1", arr_clr_o, sif.in_ready_o, busy_o);
      end
      total++;
      if (arr_dav_o !== 1'b0 || arr_data_o !== '0 || arr_meta_o !== '0 || overflow_o !== 1'b0) begin
         bad++; $display("FAIL rst_arr got dav=%b data=%h meta=%h ovf=%b exp zeros", arr_dav_o, arr_data_o, arr_meta_o, overflow_o);
      end
      @(negedge clk);
      total++;
      if (arr_clr_o !== 1'b0 || sif.in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         bad++; $display("FAIL rst_load got clr=%b rdy=%b busy=%b exp 0/1/0", arr_clr_o, sif.in_ready_o, busy_o);
      end
      total++;
      if (sif.out_valid_o !== 1'b0 || sif.out_last_o !== 1'b0 || sif.out_data_o !== '0 || sif.out_meta_o !== '0) begin
         bad++; $display("FAIL rst_out got v=%b l=%b d=%h m=%h exp zeros", sif.out_valid_o, sif.out_last_o, sif.out_data_o, sif.out_meta_o);
      end
   endtask

   task automatic test_basic();
      send(8'd5, 1'b0);
      total++;
      if (arr_dav_o !== 1'b1 || arr_data_o !== 8'd5 || arr_meta_o !== meta_of(8'd5)) begin
         bad++; $display("FAIL basic_ingest got dav=%b data=%0d exp dav=1 data=5", arr_dav_o, arr_data_o);
      end
      send(8'd200, 1'b0);
      send(8'd17, 1'b0);
      send(8'd99, 1'b1);
      go_idle();
      total++;
      if (busy_o !== 1'b1 || sif.in_ready_o !== 1'b0 || sif.out_valid_o !== 1'b0 || arr_dav_o !== 1'b1 || arr_data_o !== 8'd99) begin
         bad++; $display("FAIL basic_settle got busy=%b rdy=%b v=%b dav=%b d=%0d exp 1/0/0/1/99", busy_o, sif.in_ready_o, sif.out_valid_o, arr_dav_o, arr_data_o);
      end
      exp_k[0] = 8'd200; exp_k[1] = 8'd99; exp_k[2] = 8'd17; exp_k[3] = 8'd5;
      drain_check(4, "basic");
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 18; i++) begin
         send(SB'(i), (i == 18));
         if (i == 16) begin
            total++;
            if (overflow_o !== 1'b0 || arr_dav_o !== 1'b1) begin
               bad++; $display("FAIL ovf_at16 got ovf=%b dav=%b exp 0/1", overflow_o, arr_dav_o);
            end
         end
         if (i == 17) begin
            total++;
            if (overflow_o !== 1'b1 || arr_dav_o !== 1'b0) begin
               bad++; $display("FAIL ovf_at17 got ovf=%b dav=%b exp 1/0", overflow_o, arr_dav_o);
            end
         end
      end
      go_idle();
      total++;
      if (overflow_o !== 1'b1 || busy_o !== 1'b1) begin
         bad++; $display("FAIL ovf_settle got ovf=%b busy=%b exp 1/1", overflow_o, busy_o);
      end
      for (int i = 0; i < 16; i++) exp_k[i] = SB'(16 - i);
      drain_check(16, "ovf");
      total++;
      if (overflow_o !== 1'b0) begin
         bad++; $display("FAIL ovf_cleared got=%b exp=0", overflow_o);
      end
   endtask

   task automatic test_ready_toggle();
      int pat [6];
      int e;
      pat = '{1, 0, 0, 1, 1, 1};
      exp_k[0] = 8'd40; exp_k[1] = 8'd30; exp_k[2] = 8'd20; exp_k[3] = 8'd10;
      send(8'd40, 1'b0);
      send(8'd10, 1'b0);
      send(8'd30, 1'b0);
      send(8'd20, 1'b1);
      go_idle();
      @(negedge clk);
      e = 0;
      for (int c = 0; c < 6; c++) begin
         sif.out_ready_i = pat[c][0];
         total++;
         if (sif.out_valid_o !== 1'b1 || sif.out_data_o !== exp_k[e] || sif.out_last_o !== (e == 3)) begin
            bad++; $display("FAIL bp_cyc%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b", c, sif.out_valid_o, sif.out_data_o, sif.out_last_o, exp_k[e], (e == 3));
         end
         @(negedge clk);
         if (pat[c] != 0) e++;
      end
      total++;
      if (arr_clr_o !== 1'b1 || sif.out_valid_o !== 1'b0) begin
         bad++; $display("FAIL bp_clear got clr=%b v=%b exp 1/0", arr_clr_o, sif.out_valid_o);
      end
      sif.out_ready_i = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_drain();
      sif.out_ready_i = 1'b1;
      send(8'd8, 1'b0);
      send(8'd3, 1'b0);
      send(8'd6, 1'b0);
      send(8'd1, 1'b1);
      go_idle();
      @(negedge clk);
      total++;
      if (sif.out_data_o !== 8'd8) begin
         bad++; $display("FAIL rdrain_0 got=%0d exp=8", sif.out_data_o);
      end
      @(negedge clk);
      total++;
      if (sif.out_data_o !== 8'd6) begin
         bad++; $display("FAIL rdrain_1 got=%0d exp=6", sif.out_data_o);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (sif.out_valid_o !== 1'b0 || arr_clr_o !== 1'b1) begin
         bad++; $display("FAIL rdrain_rst got v=%b clr=%b exp 0/1", sif.out_valid_o, arr_clr_o);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (sif.in_ready_o !== 1'b1 || arr_clr_o !== 1'b0) begin
         bad++; $display("FAIL rdrain_load got rdy=%b clr=%b exp 1/0", sif.in_ready_o, arr_clr_o);
      end
      send(8'd7, 1'b0);
      send(8'd9, 1'b1);
      go_idle();
      exp_k[0] = 8'd9; exp_k[1] = 8'd7;
      drain_check(2, "rdrain_new");
   endtask

   task automatic test_single();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (sif.in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++; $display("FAIL single_idle%0d got rdy=%b busy=%b exp 1/0", i, sif.in_ready_o, busy_o);
         end
         @(negedge clk);
      end
      send(8'd77, 1'b1);
      go_idle();
      exp_k[0] = 8'd77;
      drain_check(1, "single");
   endtask

`ifdef CELL_SORT_CTRL_TIMEOUT_EN
   task automatic test_timeout();
      send(8'd4, 1'b0);
      send(8'd12, 1'b0);
      send(8'd8, 1'b0);
      go_idle();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (sif.in_ready_o !== 1'b1) begin
            bad++; $display("FAIL tmo_idle%0d got rdy=%b exp 1", i, sif.in_ready_o);
         end
         @(negedge clk);
      end
      total++;
      if (sif.in_ready_o !== 1'b0 || busy_o !== 1'b1 || sif.out_valid_o !== 1'b0) begin
         bad++; $display("FAIL tmo_settle got rdy=%b busy=%b v=%b exp 0/1/0", sif.in_ready_o, busy_o, sif.out_valid_o);
      end
      exp_k[0] = 8'd12; exp_k[1] = 8'd8; exp_k[2] = 8'd4;
      drain_check(3, "tmo");
   endtask
`else
   task automatic test_long_idle();
      send(8'd50, 1'b0);
      go_idle();
      for (int i = 0; i < 20; i++) begin
         total++;
         if (sif.in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++; $display("FAIL idle_hold%0d got rdy=%b busy=%b exp 1/0", i, sif.in_ready_o, busy_o);
         end
         @(negedge clk);
      end
      send(8'd60, 1'b1);
      go_idle();
      exp_k[0] = 8'd60; exp_k[1] = 8'd50;
      drain_check(2, "idle");
   endtask
`endif

   initial begin
      sif.in_valid_i  = 1'b0;
      sif.in_last_i   = 1'b0;
      sif.in_data_i   = '0;
      sif.in_meta_i   = '0;
      sif.out_ready_i = 1'b1;
      test_reset();
      test_basic();
      test_overflow();
      test_ready_toggle();
      test_reset_drain();
      test_single();
`ifdef CELL_SORT_CTRL_TIMEOUT_EN
      test_timeout();
`else
      test_long_idle();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cell_sort_ctrl.md
Name: cell_sort_ctrl

Overview:
- Sequencer for a systolic insertion-sort array of NCELLS unit cells, with a common data/metadata broadcast and cell-to-cell push chain.
- Accepts one frame of keyed items on a valid/ready stream and broadcasts each item to the array with a one-cycle strobe.
- At frame end, drains the sorted contents by index onto a valid/ready output stream, then clears the array for the next frame.
- Sits between the upstream packetiser and the array; it owns the array's clear and data-valid lines.

Parameters:
- NCELLS, 16: number of cells in the array, and the maximum items per frame.
- SORTB, 8: sort key width.
- METAB, 32: metadata width.
- CNTB, $clog2(NCELLS+1): item counter width (derived; do not override).
- TIMEOUT, 64: idle cycles before auto-flush (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data_i  in  SORTB  item key.
- in_meta_i  in  METAB  item metadata.
- in_last_i  in  1  final item of the frame.
- in_valid_i  in  1  item valid.
- in_ready_o  out  1  controller accepts the item.
- arr_data_o  out  SORTB  broadcast key to all cells.
- arr_meta_o  out  METAB  broadcast metadata to all cells.
- arr_dav_o  out  1  broadcast strobe (cell dav).
- arr_clr_o  out  1  array clear (OR'd into the cells' rst).
- arr_data_i  in  NCELLS*SORTB  flattened cell keys; cell k at bits [k*SORTB +: SORTB].
- arr_meta_i  in  NCELLS*METAB  flattened cell metadata, same layout.
- out_data_o  out  SORTB  sorted key.
- out_meta_o  out  METAB  sorted metadata.
- out_last_o  out  1  final sorted item of the frame.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  downstream ready.
- overflow_o  out  1  sticky per frame: items were dropped.
- busy_o  out  1  high in any state other than LOAD.

Behaviour:
- FSM states: CLEAR, LOAD, SETTLE, DRAIN. rst forces CLEAR, count=0, rd_idx=0, overflow_o=0.
- Reset mid-frame discards all partial load/drain state. Reset values:
  - arr_dav_o=0, out_valid_o=0, out_last_o=0.
  - arr_data_o and arr_meta_o = 0.
  - arr_clr_o=1 (decode of CLEAR).
  - in_ready_o=0.
- CLEAR: arr_clr_o=1 for exactly one cycle; count, rd_idx and overflow_o are zeroed; next state is LOAD.
- LOAD:
  - in_ready_o=1 combinationally.
  - On an in_valid_i & in_ready_o handshake with count<NCELLS: register key and metadata onto arr_*_o, pulse arr_dav_o next cycle, count++.
  - With count==NCELLS, the item is accepted but dropped: no dav, overflow_o<=1.
  - A handshake with in_last_i set moves to SETTLE.
  - Ingest latency: one cycle from handshake to arr_dav_o. Throughput: one item per clock.
- SETTLE: in_ready_o=0; lasts one cycle so the final dav is absorbed by the cells; then DRAIN, or CLEAR if count==0.
- DRAIN:
  - out_data_o/out_meta_o = cell[rd_idx], selected combinationally from arr_*_i; out_valid_o=1.
  - out_last_o=(rd_idx==count-1).
  - On out_valid_o & out_ready_i: rd_idx++. On the last handshake go to CLEAR.
  - Output order is cell 0 first, which is descending for a non-reversed array.
  - out_ready_i low holds the data stable; valid is never withdrawn.
- Frame of exactly NCELLS items: no overflow. Item NCELLS+1 onward: dropped, overflow_o=1, cleared only in CLEAR.
- Single-item frame with last: SETTLE, then DRAIN emits one item with out_last_o=1.
- in_valid_i low for any number of cycles in LOAD: no state change (feature off).
- Frame turnaround overhead: 1 SETTLE + 1 CLEAR cycle.

Optional Feature:
- Macro: CELL_SORT_CTRL_TIMEOUT_EN.
- Defined: an idle counter in LOAD counts cycles with no handshake, and resets on any handshake or on leaving LOAD.
  - Reaching TIMEOUT with count>0: act as if in_last_i was seen and go to SETTLE.
  - count==0: no effect.
  - out_last_o still marks the final drained item.
- Undefined: the counter does not exist; only in_last_i ends a frame.

Decomposition:
- Package cell_sort_pkg:
  - state_t enum {CLEAR, LOAD, SETTLE, DRAIN}.
  - Default SORTB/METAB localparams.
  - Function cell_sel(flat, idx) for the flattened slice.
- One natural sub-module, cell_sort_rdmux: parameterised NCELLS:1 index mux for data+metadata, purely combinational.
- The FSM, counters and handshakes stay in cell_sort_ctrl.

Test Plan:
- rst 3 cycles, then release → arr_clr_o=1 for one cycle, then in_ready_o=1, busy_o=0, all outputs zero.
- Feed keys 5,200,17,99 (last on 99) into a 16-cell array, out_ready_i=1 → SETTLE, then out 200,99,17,5 on consecutive cycles with out_last_o on 5, then a CLEAR pulse.
- Feed 18 items, keys 1..18, last on 18 → overflow_o=1; drain emits 16 items, 16..1, with no 17/18 since those items were dropped; overflow_o clears in CLEAR.
- DRAIN with out_ready_i toggling 1,0,0,1 → data held stable while ready=0; no duplicate and no skipped index.
- Assert rst during DRAIN after 2 of 4 items → out_valid_o=0 next cycle, CLEAR pulse, new frame sorts correctly.
- With CELL_SORT_CTRL_TIMEOUT_EN and TIMEOUT=8: feed 3 items with no last, then idle 8 cycles → SETTLE, then 3 items drained with out_last_o on the third.
